axi_lite_kernel_scheduler: RTL and testbench
============================================

// Module: axi_lite_kernel_scheduler
// PURPOSE
//  AXI4-Lite control slave and round-robin job dispatcher for KERNEL_NUM compute kernels in the action wrapper.
//  Holds global control, init address and per-kernel interrupt status/enable; dispatches job_start requests to idle kernels.
//  Tracks per-kernel busy state; raises a level interrupt on masked completions.
//  Successor to the fixed 8-kernel global slave: any kernel count, fair arbitration, W1C interrupts, independent AW/W acceptance.
// PARAMETERS
//  KERNEL_NUM  8   kernels served, 1..32
//  ADDR_WIDTH  32  AXI address width; decode uses addr[7:0], data fixed at 32 bits
// PORTS
//  clk              in   1        single clock, all logic rising-edge
//  rst              in   1        asynchronous, active-high reset
//  s_axi_aw*        -    -        awvalid/awready/awaddr[ADDR_WIDTH]/awprot[3] (awprot ignored)
//  s_axi_w*         -    -        wvalid/wready/wdata[32]/wstrb[4]
//  s_axi_b*         -    -        bvalid/bready/bresp[2]
//  s_axi_ar*        -    -        arvalid/arready/araddr[ADDR_WIDTH]/arprot[3] (arprot ignored)
//  s_axi_r*         -    -        rvalid/rready/rdata[32]/rresp[2]
//  i_action_type    in   32       constant read at 0x10
//  job_start        in   1        one-cycle request to dispatch one job
//  kernel_complete  in   K        per-kernel done level; rising edge = completion
//  kernel_start     out  K        one-hot single-cycle start pulse
//  kernel_busy      out  K        busy flags
//  manager_start    out  1        GLOBAL_CONTROL[0]
//  init_addr        out  64       {INIT_HI, INIT_LO}
//  new_job          out  1        at least one kernel idle and no start pulse this cycle
//  job_done         out  1        no kernel busy
//  o_interrupt      out  1        registered |(INTR_STATUS & INTR_ENABLE) & GLOBAL_CONTROL[1]
// BEHAVIOUR
//  Reset: awready=wready=arready=1; bvalid=rvalid=0; rdata=0; bresp=rresp=0 (OKAY); all registers, busy, start and interrupt 0.
//  Reset: kernel_complete history is all-ones, so a complete held high through reset gives no edge.
//  Write: AW and W are captured independently in either order. awready drops after AW capture; wready drops after W capture.
//  Write: when both are held, the register commits and bvalid=1 on the next cycle. bvalid holds until bready; then awready=wready=1.
//  Write: wstrb masks per byte on RW registers. For W1C, only strobed bytes clear.
//  Read: arready=~rvalid. AR handshake -> rdata/rvalid registered next cycle (1-cycle latency). rvalid holds until rready; arready re-rises the same cycle.
//  Read: unmapped address -> 0x5A5AA5A5, OKAY. Unmapped write -> ignored, OKAY.
//  Map: 0x10 ACTION_TYPE RO | 0x30 INTR_STATUS W1C [K-1:0], [31]=DROP sticky | 0x34 INTR_ENABLE RW
//  Map: 0x38 GLOBAL_CONTROL RW [0] start, [1] irq_en | 0x3C INIT_HI RW | 0x40 INIT_LO RW
//  Map: 0x44 KERNEL_BUSY RO | 0x48 COMPLETION_CNT RO, 32b, wraps, counts all completion edges
//  Dispatch FSM: IDLE -> (job_start & manager_start & any idle) GRANT -> IDLE.
//  GRANT: kernel_start pulses one cycle after job_start, 1 cycle wide, to the first idle kernel after the last granted index (round-robin, wraps K-1 -> 0).
//  job_start while in GRANT, with no kernel idle, or with manager_start=0 -> dropped; sets INTR_STATUS[31].
//  Busy: set on the start pulse, cleared on the completion edge. Start and completion on one kernel in the same cycle -> busy stays 1.
//  Status: completion edge sets STATUS[k]. Set and W1C in the same cycle -> set wins.
//  Status: STATUS[31] contributes to o_interrupt when ENABLE[31].
//  Clearing manager_start mid-job: in-flight kernels continue and busy clears normally; new dispatch is blocked.
//  Reset mid-transaction: outstanding AXI handshakes are abandoned; the master must reissue.
// CONFIGURATION
//  KSCHED_PERF_CNT_EN defined: 0x80+4*k returns a 32b wrapping per-kernel completion count, k<KERNEL_NUM, cleared by reset only.
//  KSCHED_PERF_CNT_EN undefined: counters absent; 0x80.. reads 0x5A5AA5A5.
// STRUCTURE
//  ksched_pkg: register address localparams, RDATA_UNMAPPED, GLOBAL_CONTROL bit indices, STATUS_DROP_BIT=31.
//  Sub-module rr_arbiter #(N): request vector + advance -> one-hot grant, rotating pointer.
//  All else is flat in this module.
// TESTING
//  1 Write 0x38=0x3 with AW two cycles before W, then W before AW -> both commit; manager_start=1; one bvalid each.
//  2 K=8, all idle, three job_start pulses 4 cycles apart -> kernel_start 0x01, 0x02, 0x04; kernel_busy=0x07; new_job=1.
//  3 All 8 busy, job_start -> no pulse; STATUS=0x80000000. Raise complete[3] -> next job goes to kernel 3.
//  4 ENABLE=0x0F, irq_en=1, complete[2] edge -> o_interrupt=1, STATUS[2]=1, COUNT+1. W1C 0x04 with wstrb=0x1 -> o_interrupt=0.
//  5 Same-cycle complete[5] edge and W1C of bit 5 -> STATUS[5] stays 1. Read 0x7C -> 0x5A5AA5A5.
//  6 KSCHED_PERF_CNT_EN: complete[1] twice -> read 0x84=2; assert rst mid-read -> rvalid=0, counters 0.

Source files
------------

// File: rtl/ksched_pkg.sv
// rtl/ksched_pkg.sv - register map, field indices and byte-strobe helpers for the kernel scheduler
package ksched_pkg;

  localparam logic [7:0] ADDR_ACTION_TYPE    = 8'h10;
  localparam logic [7:0] ADDR_INTR_STATUS    = 8'h30;
  localparam logic [7:0] ADDR_INTR_ENABLE    = 8'h34;
  localparam logic [7:0] ADDR_GLOBAL_CONTROL = 8'h38;
  localparam logic [7:0] ADDR_INIT_HI        = 8'h3C;
  localparam logic [7:0] ADDR_INIT_LO        = 8'h40;
  localparam logic [7:0] ADDR_KERNEL_BUSY    = 8'h44;
  localparam logic [7:0] ADDR_COMPLETION_CNT = 8'h48;
  localparam logic [7:0] ADDR_PERF_BASE      = 8'h80;

  localparam logic [31:0] RDATA_UNMAPPED = 32'h5A5A_A5A5;

  localparam int GC_START_BIT    = 0;
  localparam int GC_IRQ_EN_BIT   = 1;
  localparam int STATUS_DROP_BIT = 31;

  typedef enum logic {
    DISP_IDLE  = 1'b0,
    DISP_GRANT = 1'b1
  } disp_state_e;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] m;
    m = strb_to_mask(strb);
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/axi_lite_kernel_scheduler_if.sv
// rtl/axi_lite_kernel_scheduler_if.sv - AXI4-Lite control bus bundle with master/slave views
interface axi_lite_kernel_scheduler_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  wvalid;
  logic                  wready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  rvalid;
  logic                  rready;
  logic [31:0]           rdata;
  logic [1:0]            rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_kernel_scheduler_rr_arbiter.sv
// rtl/axi_lite_kernel_scheduler_rr_arbiter.sv - round-robin one-hot arbiter with rotating last-grant pointer
module rr_arbiter #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] last_q;
  logic [PW-1:0] idx_hi;
  logic [PW-1:0] idx_lo;
  logic [N-1:0]  grant_hi;
  logic [N-1:0]  grant_lo;
  logic          any_hi;

  // Lowest requester above the last grant wins; otherwise wrap to the lowest requester overall
  always_comb begin
    grant_hi = '0;
    grant_lo = '0;
    idx_hi   = '0;
    idx_lo   = '0;
    any_hi   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant_lo    = '0;
        grant_lo[k] = 1'b1;
        idx_lo      = PW'(k);
      end
      if (req[k] && (k > int'(last_q))) begin
        grant_hi    = '0;
        grant_hi[k] = 1'b1;
        idx_hi      = PW'(k);
        any_hi      = 1'b1;
      end
    end
  end

  assign grant = any_hi ? grant_hi : grant_lo;

  // Pointer starts at N-1 so the first grant after reset goes to index 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= PW'(N - 1);
    end else if (advance && (|req)) begin
      last_q <= any_hi ? idx_hi : idx_lo;
    end
  end
endmodule

// File: rtl/axi_lite_kernel_scheduler.sv
// rtl/axi_lite_kernel_scheduler.sv - AXI4-Lite control slave and round-robin kernel dispatcher; KSCHED_PERF_CNT_EN adds per-kernel completion counters at 0x80
module axi_lite_kernel_scheduler
  import ksched_pkg::*;
#(
  parameter int KERNEL_NUM = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  axi_lite_kernel_scheduler_if.slave s_axi,
  input  logic [31:0]               i_action_type,
  input  logic                      job_start,
  input  logic [KERNEL_NUM-1:0]     kernel_complete,
  output logic [KERNEL_NUM-1:0]     kernel_start,
  output logic [KERNEL_NUM-1:0]     kernel_busy,
  output logic                      manager_start,
  output logic [63:0]               init_addr,
  output logic                      new_job,
  output logic                      job_done,
  output logic                      o_interrupt
);
  localparam int K = KERNEL_NUM;

  // write channel state
  logic                  aw_held;
  logic                  w_held;
  logic                  bvalid_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            wstrb_q;
  logic                  wr_commit;
  logic [7:0]            wr_addr;
  logic [31:0]           w1c_mask;

  // read channel state
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [31:0] rd_mux;
  logic [7:0]  rd_addr;

  // registers
  logic [K-1:0] status_k;
  logic         status_drop;
  logic [31:0]  status_word;
  logic [31:0]  intr_enable;
  logic [31:0]  global_control;
  logic [31:0]  init_hi;
  logic [31:0]  init_lo;
  logic [31:0]  completion_cnt;
  logic [K-1:0] comp_q;
  logic [K-1:0] comp_edge;
  logic [31:0]  edge_count;
  logic [K-1:0] busy_q;
  logic         irq_q;

  // dispatcher
  disp_state_e  state_q;
  disp_state_e  state_nx;
  logic [K-1:0] arb_grant;
  logic         arb_advance;
  logic         drop_evt;
  logic         any_idle;

  logic unused_bits;
  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, awaddr_q, s_axi.araddr};

  assign s_axi.awready = ~aw_held;
  assign s_axi.wready  = ~w_held;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = ~rvalid_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = 2'b00;

  assign wr_commit = aw_held & w_held & ~bvalid_q;
  assign wr_addr   = awaddr_q[7:0];
  assign w1c_mask  = (wr_commit && (wr_addr == ADDR_INTR_STATUS)) ?
                     (wdata_q & strb_to_mask(wstrb_q)) : 32'h0;
  assign rd_addr   = s_axi.araddr[7:0];

  assign comp_edge     = kernel_complete & ~comp_q;
  assign any_idle      = |(~busy_q);
  assign kernel_busy   = busy_q;
  assign manager_start = global_control[GC_START_BIT];
  assign init_addr     = {init_hi, init_lo};
  assign new_job       = any_idle & ~(|kernel_start);
  assign job_done      = ~(|busy_q);
  assign o_interrupt   = irq_q;

  // AW and W latch independently; once both are held the write commits and B is raised
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid_q <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      if (s_axi.awvalid && !aw_held) begin
        aw_held  <= 1'b1;
        awaddr_q <= s_axi.awaddr;
      end
      if (s_axi.wvalid && !w_held) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi.wdata;
        wstrb_q <= s_axi.wstrb;
      end
      if (wr_commit) begin
        bvalid_q <= 1'b1;
      end
      if (bvalid_q && s_axi.bready) begin
        bvalid_q <= 1'b0;
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
      end
    end
  end

  // Status view: kernel bits low, drop flag OR'd into bit 31
  always_comb begin
    status_word                  = 32'(status_k);
    status_word[STATUS_DROP_BIT] = status_word[STATUS_DROP_BIT] | status_drop;
  end

  // Number of completion edges this cycle
  always_comb begin
    edge_count = 32'h0;
    for (int k = 0; k < K; k++) begin
      edge_count = edge_count + 32'(comp_edge[k]);
    end
  end

`ifdef KSCHED_PERF_CNT_EN
  logic [31:0] perf_cnt [K];

  // Per-kernel completion counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < K; k++) perf_cnt[k] <= 32'h0;
    end else begin
      for (int k = 0; k < K; k++) begin
        if (comp_edge[k]) perf_cnt[k] <= perf_cnt[k] + 32'h1;
      end
    end
  end
`endif

  // Read address decode
  always_comb begin
    rd_mux = RDATA_UNMAPPED;
    case (rd_addr)
      ADDR_ACTION_TYPE:    rd_mux = i_action_type;
      ADDR_INTR_STATUS:    rd_mux = status_word;
      ADDR_INTR_ENABLE:    rd_mux = intr_enable;
      ADDR_GLOBAL_CONTROL: rd_mux = global_control;
      ADDR_INIT_HI:        rd_mux = init_hi;
      ADDR_INIT_LO:        rd_mux = init_lo;
      ADDR_KERNEL_BUSY:    rd_mux = 32'(busy_q);
      ADDR_COMPLETION_CNT: rd_mux = completion_cnt;
      default:             ;
    endcase
`ifdef KSCHED_PERF_CNT_EN
    for (int k = 0; k < K; k++) begin
      if (rd_addr == (ADDR_PERF_BASE + 8'(4 * k))) rd_mux = perf_cnt[k];
    end
`endif
  end

  // One-cycle read latency; arready stays low while a response is pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= 32'h0;
    end else if (s_axi.arvalid && !rvalid_q) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_mux;
    end else if (rvalid_q && s_axi.rready) begin
      rvalid_q <= 1'b0;
    end
  end

  // Register file, status/busy tracking and the registered interrupt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_k       <= '0;
      status_drop    <= 1'b0;
      intr_enable    <= 32'h0;
      global_control <= 32'h0;
      init_hi        <= 32'h0;
      init_lo        <= 32'h0;
      completion_cnt <= 32'h0;
      comp_q         <= '1;
      busy_q         <= '0;
      irq_q          <= 1'b0;
    end else begin
      comp_q         <= kernel_complete;
      status_k       <= (status_k & ~w1c_mask[K-1:0]) | comp_edge;
      status_drop    <= (status_drop & ~w1c_mask[STATUS_DROP_BIT]) | drop_evt;
      completion_cnt <= completion_cnt + edge_count;
      busy_q         <= (busy_q & ~comp_edge) | kernel_start;
      irq_q          <= (|(status_word & intr_enable)) & global_control[GC_IRQ_EN_BIT];
      if (wr_commit) begin
        case (wr_addr)
          ADDR_INTR_ENABLE:    intr_enable    <= strb_merge(intr_enable, wdata_q, wstrb_q);
          ADDR_GLOBAL_CONTROL: global_control <= strb_merge(global_control, wdata_q, wstrb_q);
          ADDR_INIT_HI:        init_hi        <= strb_merge(init_hi, wdata_q, wstrb_q);
          ADDR_INIT_LO:        init_lo        <= strb_merge(init_lo, wdata_q, wstrb_q);
          default:             ;
        endcase
      end
    end
  end

  rr_arbiter #(.N(K)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (~busy_q),
    .advance (arb_advance),
    .grant   (arb_grant)
  );

  // Dispatch state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= DISP_IDLE;
    else     state_q <= state_nx;
  end

  // Dispatch decisions: accept into GRANT, pulse the arbiter choice, drop anything else
  always_comb begin
    state_nx     = state_q;
    kernel_start = '0;
    arb_advance  = 1'b0;
    drop_evt     = 1'b0;
    case (state_q)
      DISP_IDLE: begin
        if (job_start) begin
          if (manager_start && any_idle) state_nx = DISP_GRANT;
          else                           drop_evt = 1'b1;
        end
      end
      DISP_GRANT: begin
        kernel_start = arb_grant;
        arb_advance  = 1'b1;
        state_nx     = DISP_IDLE;
        if (job_start) drop_evt = 1'b1;
      end
      default: state_nx = DISP_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi_lite_kernel_scheduler.sv
// tb/tb_axi_lite_kernel_scheduler.sv - directed table-driven bench for the kernel scheduler
module tb_axi_lite_kernel_scheduler;
  localparam int K = 8;
  localparam logic [31:0] ACTION = 32'hC0DE_1234;
  localparam logic [31:0] UNMAP  = 32'h5A5A_A5A5;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         job_start;
  logic [K-1:0] kernel_complete;
  logic [K-1:0] kernel_start;
  logic [K-1:0] kernel_busy;
  logic         manager_start;
  logic [63:0]  init_addr;
  logic         new_job;
  logic         job_done;
  logic         o_interrupt;

  int n_tests = 0;
  int n_fail  = 0;

  axi_lite_kernel_scheduler_if #(.ADDR_WIDTH(32)) axi ();

  axi_lite_kernel_scheduler #(.KERNEL_NUM(K), .ADDR_WIDTH(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .s_axi           (axi),
    .i_action_type   (ACTION),
    .job_start       (job_start),
    .kernel_complete (kernel_complete),
    .kernel_start    (kernel_start),
    .kernel_busy     (kernel_busy),
    .manager_start   (manager_start),
    .init_addr       (init_addr),
    .new_job         (new_job),
    .job_done        (job_done),
    .o_interrupt     (o_interrupt)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic axi_write(input string nm, input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int aw_dly, input int w_dly);
    int t;
    int n;
    bit aw_done, w_done, aw_hs, w_hs;
    t = 0; aw_done = 0; w_done = 0; aw_hs = 0; w_hs = 0;
    axi.awaddr = {24'h0, addr};
    axi.wdata  = data;
    axi.wstrb  = strb;
    axi.bready = 1'b0;
    while (!(aw_done && w_done) && t < 40) begin
      @(negedge clk);
      if (aw_hs) begin axi.awvalid = 1'b0; aw_done = 1; aw_hs = 0; end
      if (w_hs)  begin axi.wvalid  = 1'b0; w_done  = 1; w_hs  = 0; end
      if (!aw_done && t >= aw_dly) axi.awvalid = 1'b1;
      if (!w_done  && t >= w_dly)  axi.wvalid  = 1'b1;
      aw_hs = axi.awvalid && axi.awready;
      w_hs  = axi.wvalid  && axi.wready;
      t++;
    end
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    n = 0;
    while (!axi.bvalid && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    chk({nm, "_bhold"}, axi.bvalid, 1);
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    chk({nm, "_bdone"}, {axi.bvalid, axi.awready, axi.wready}, 3'b011);
  endtask

  task automatic axi_read(input string nm, input logic [7:0] addr, input logic [31:0] exp);
    int n;
    @(negedge clk);
    axi.araddr  = {24'h0, addr};
    axi.arvalid = 1'b1;
    axi.rready  = 1'b0;
    n = 0;
    while (!axi.arready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    axi.arvalid = 1'b0;
    chk({nm, "_rvalid"}, axi.rvalid, 1);
    chk(nm, axi.rdata, exp);
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
  endtask

  task automatic job_pulse(input string nm, input logic [K-1:0] exp_start);
    @(negedge clk);
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    chk(nm, kernel_start, exp_start);
    step(3);
  endtask

  initial begin
    vec_t         regv [19];
    logic [K-1:0] disp_exp [8];

    regv[0]  = '{1'b0, 8'h10, 32'h0,         4'h0, ACTION,        "rd_action"};
    regv[1]  = '{1'b0, 8'h48, 32'h0,         4'h0, 32'h0,         "rd_cnt_rst"};
    regv[2]  = '{1'b0, 8'h30, 32'h0,         4'h0, 32'h0,         "rd_status_rst"};
    regv[3]  = '{1'b1, 8'h34, 32'h1234_5678, 4'hF, 32'h0,         "wr_enable"};
    regv[4]  = '{1'b0, 8'h34, 32'h0,         4'h0, 32'h1234_5678, "rd_enable"};
    regv[5]  = '{1'b1, 8'h34, 32'hAABB_CCDD, 4'h5, 32'h0,         "wr_enable_strb"};
    regv[6]  = '{1'b0, 8'h34, 32'h0,         4'h0, 32'h12BB_56DD, "rd_enable_strb"};
    regv[7]  = '{1'b1, 8'h3C, 32'hDEAD_BEEF, 4'hF, 32'h0,         "wr_init_hi"};
    regv[8]  = '{1'b1, 8'h40, 32'h0000_1000, 4'hF, 32'h0,         "wr_init_lo"};
    regv[9]  = '{1'b0, 8'h3C, 32'h0,         4'h0, 32'hDEAD_BEEF, "rd_init_hi"};
    regv[10] = '{1'b0, 8'h40, 32'h0,         4'h0, 32'h0000_1000, "rd_init_lo"};
    regv[11] = '{1'b1, 8'h7C, 32'hFFFF_FFFF, 4'hF, 32'h0,         "wr_unmapped"};
    regv[12] = '{1'b0, 8'h7C, 32'h0,         4'h0, UNMAP,         "rd_unmapped"};
    regv[13] = '{1'b1, 8'h10, 32'h0,         4'hF, 32'h0,         "wr_action_ro"};
    regv[14] = '{1'b0, 8'h10, 32'h0,         4'h0, ACTION,        "rd_action_ro"};
    regv[15] = '{1'b1, 8'h44, 32'h0000_00FF, 4'hF, 32'h0,         "wr_busy_ro"};
    regv[16] = '{1'b0, 8'h44, 32'h0,         4'h0, 32'h0,         "rd_busy_ro"};
    regv[17] = '{1'b1, 8'h34, 32'h0,         4'hF, 32'h0,         "wr_enable_clr"};
    regv[18] = '{1'b0, 8'h34, 32'h0,         4'h0, 32'h0,         "rd_enable_clr"};

    disp_exp[0] = 8'h01; disp_exp[1] = 8'h02; disp_exp[2] = 8'h04; disp_exp[3] = 8'h08;
    disp_exp[4] = 8'h10; disp_exp[5] = 8'h20; disp_exp[6] = 8'h40; disp_exp[7] = 8'h80;

    rst = 1'b1;
    job_start = 1'b0;
    kernel_complete = 8'h01;
    axi.awvalid = 1'b0; axi.awaddr = '0; axi.awprot = 3'b0;
    axi.wvalid  = 1'b0; axi.wdata  = '0; axi.wstrb  = 4'h0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0; axi.araddr = '0; axi.arprot = 3'b0;
    axi.rready  = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);

    chk("rst_ready", {axi.awready, axi.wready, axi.arready}, 3'b111);
    chk("rst_valid", {axi.bvalid, axi.rvalid}, 2'b00);
    chk("rst_rdata", axi.rdata, 32'h0);
    chk("rst_resp", {axi.bresp, axi.rresp}, 4'h0);
    chk("rst_busy_start", {kernel_busy, kernel_start}, 16'h0);
    chk("rst_flags", {manager_start, new_job, job_done, o_interrupt}, 4'b0110);
    chk("rst_init_addr", init_addr, 64'h0);
    kernel_complete = 8'h00;
    step(2);

    for (int i = 0; i < 19; i++) begin
      if (regv[i].wr) axi_write(regv[i].name, regv[i].addr, regv[i].data, regv[i].strb, i % 2, (i / 2) % 2);
      else            axi_read(regv[i].name, regv[i].addr, regv[i].exp);
    end
    chk("init_addr", init_addr, 64'hDEAD_BEEF_0000_1000);

    axi_write("t1_aw_first", 8'h38, 32'h3, 4'hF, 0, 2);
    chk("t1_ms_a", manager_start, 1);
    axi_write("t1_clear", 8'h38, 32'h0, 4'hF, 0, 0);
    chk("t1_ms_clr", manager_start, 0);
    axi_write("t1_w_first", 8'h38, 32'h3, 4'hF, 2, 0);
    chk("t1_ms_b", manager_start, 1);
    axi_read("t1_rd_gc", 8'h38, 32'h3);

    for (int i = 0; i < 3; i++) job_pulse($sformatf("t2_start%0d", i), disp_exp[i]);
    chk("t2_busy", kernel_busy, 8'h07);
    chk("t2_new_job", {new_job, job_done}, 2'b10);

    for (int i = 3; i < 8; i++) job_pulse($sformatf("t3_start%0d", i), disp_exp[i]);
    chk("t3_busy_full", kernel_busy, 8'hFF);
    chk("t3_new_job_full", {new_job, job_done}, 2'b00);
    job_pulse("t3_no_idle", 8'h00);
    axi_read("t3_status_drop", 8'h30, 32'h8000_0000);
    @(negedge clk);
    kernel_complete[3] = 1'b1;
    step(1);
    chk("t3_busy_k3", kernel_busy, 8'hF7);
    job_pulse("t3_rr_k3", 8'h08);
    chk("t3_busy_refull", kernel_busy, 8'hFF);
    axi_read("t3_cnt", 8'h48, 32'h1);
    kernel_complete[3] = 1'b0;
    axi_write("t3_w1c_all", 8'h30, 32'hFFFF_FFFF, 4'hF, 0, 0);
    axi_read("t3_status_clr", 8'h30, 32'h0);

    axi_write("t4_enable", 8'h34, 32'h0000_000F, 4'hF, 0, 0);
    chk("t4_irq_idle", o_interrupt, 0);
    @(negedge clk);
    kernel_complete[2] = 1'b1;
    step(2);
    chk("t4_irq_set", o_interrupt, 1);
    axi_read("t4_status", 8'h30, 32'h0000_0004);
    axi_read("t4_cnt", 8'h48, 32'h2);
    chk("t4_busy", kernel_busy, 8'hFB);
    axi_write("t4_w1c_wrong_byte", 8'h30, 32'h0000_0004, 4'h2, 0, 0);
    axi_read("t4_status_kept", 8'h30, 32'h0000_0004);
    chk("t4_irq_kept", o_interrupt, 1);
    axi_write("t4_w1c", 8'h30, 32'h0000_0004, 4'h1, 0, 0);
    step(1);
    chk("t4_irq_clr", o_interrupt, 0);
    axi_read("t4_status_clr", 8'h30, 32'h0);
    kernel_complete[2] = 1'b0;

    @(negedge clk);
    axi.awaddr = 32'h30; axi.wdata = 32'h20; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
    chk("t5_ready", {axi.awready, axi.wready}, 2'b11);
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    kernel_complete[5] = 1'b1;
    @(negedge clk);
    chk("t5_bvalid", axi.bvalid, 1);
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    axi_read("t5_set_wins", 8'h30, 32'h0000_0020);
    axi_write("t5_w1c", 8'h30, 32'h0000_0020, 4'hF, 0, 0);
    axi_read("t5_status_clr", 8'h30, 32'h0);
    axi_read("t5_unmapped", 8'h7C, UNMAP);
    kernel_complete[5] = 1'b0;

    axi_write("ms0_gc", 8'h38, 32'h2, 4'hF, 0, 0);
    axi_write("ms0_en", 8'h34, 32'h8000_0000, 4'hF, 0, 0);
    chk("ms0_irq_idle", {manager_start, o_interrupt}, 2'b00);
    job_pulse("ms0_blocked", 8'h00);
    chk("ms0_irq_drop", o_interrupt, 1);
    axi_read("ms0_status", 8'h30, 32'h8000_0000);
    @(negedge clk);
    kernel_complete[0] = 1'b1;
    step(1);
    chk("ms0_busy_clears", kernel_busy, 8'hDA);

    kernel_complete[1] = 1'b1; step(2);
    kernel_complete[1] = 1'b0; step(2);
    kernel_complete[1] = 1'b1; step(2);
`ifdef KSCHED_PERF_CNT_EN
    axi_read("t6_perf1", 8'h84, 32'h2);
`else
    axi_read("t6_perf1", 8'h84, UNMAP);
`endif
    @(negedge clk);
    axi.araddr = 32'h84; axi.arvalid = 1'b1; axi.rready = 1'b0;
    @(negedge clk);
    axi.arvalid = 1'b0;
    chk("t6_rvalid_pre", axi.rvalid, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_rvalid", {axi.rvalid, axi.arready}, 2'b01);
    chk("t6_rst_rdata", axi.rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step(1);
    chk("t6_rst_regs", {manager_start, kernel_busy}, 9'h0);
`ifdef KSCHED_PERF_CNT_EN
    axi_read("t6_perf1_rst", 8'h84, 32'h0);
`else
    axi_read("t6_perf1_rst", 8'h84, UNMAP);
`endif
    axi_read("t6_cnt_rst", 8'h48, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: bench did not complete, %0d tests run", n_tests);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end
endmodule
